axis_frame_length_adjust: RTL and testbench
===========================================

AXIS_FRAME_LENGTH_ADJUST -- requirements
Module: axis_frame_length_adjust

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the tdata width; one beat is one data word.
REQ-003 Parameter LENGTH_WIDTH, default 16, SHALL set the width of the length ports and the beat counter.
REQ-004 clk  input  1  sole clock; all logic is on the rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 input_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  DATA_WIDTH/1/1/1/1  upstream AXI-stream, fed by the async FIFO output side.
REQ-007 output_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  DATA_WIDTH/1/1/1/1  downstream AXI-stream.
REQ-008 length_min  input  LENGTH_WIDTH  minimum frame length in beats.
REQ-009 length_max  input  LENGTH_WIDTH  maximum frame length in beats.
REQ-010 status_valid  output  1  one-cycle pulse per completed output frame.
REQ-011 status_frame_length  output  LENGTH_WIDTH  beats emitted in that frame.
REQ-012 status_padded, status_truncated  output  1 each  frame was padded or truncated.

Function
REQ-013 length_min and length_max SHALL be captured on the first accepted beat of each frame and held until that frame ends.
REQ-014 Captured values of 0 SHALL be treated as 1; the effective minimum SHALL be min(length_min, length_max).
REQ-015 The FSM SHALL have states IDLE, TRANSFER, PAD and TRUNCATE.
REQ-016 The output SHALL be a single registered stage, with latency of one clk from input handshake to output_axis_tvalid.
REQ-017 input_axis_tready SHALL equal (~output_axis_tvalid | output_axis_tready) in IDLE, TRANSFER and TRUNCATE, and SHALL be 0 in PAD and during reset.
REQ-018 IDLE -> TRANSFER on an accepted beat without tlast; the beat counter SHALL count emitted beats starting at 1.
REQ-019 When an accepted beat with tlast brings the count to at least the effective minimum, it SHALL pass unmodified and the FSM SHALL return to IDLE.
REQ-020 When an accepted beat with tlast leaves the count below the effective minimum, it SHALL be emitted with tlast=0 and tuser=0, and the FSM SHALL go to PAD.
REQ-021 In PAD, the block SHALL emit tdata=0 beats until the effective minimum is reached.
REQ-022 The final pad beat SHALL carry tlast=1 and the tuser of the original last input beat.
REQ-023 When an accepted beat without tlast brings the count to length_max, it SHALL be emitted with tlast=1 and tuser=1, and the FSM SHALL go to TRUNCATE.
REQ-024 In TRUNCATE, input beats SHALL be accepted and dropped, with no output, up to and including the input tlast beat, then the FSM SHALL return to IDLE.
REQ-025 A beat that is both tlast and at length_max SHALL pass unmodified, with no truncation flag.
REQ-026 A single-beat frame (tlast on the first beat) SHALL follow REQ-019 or REQ-020 directly from IDLE.
REQ-027 Output beats SHALL hold stable while output_axis_tvalid=1 and output_axis_tready=0.
REQ-028 status_valid SHALL pulse one cycle after the output tlast handshake, with length, padded and truncated flags valid in that cycle.
REQ-029 The counter SHALL not wrap: length_max bounds it at or below 2^LENGTH_WIDTH-1.
REQ-030 A new frame SHALL be accepted in the cycle after the output tlast handshake, with no bubble beyond the register stage.

Reset
REQ-031 On rst, asynchronously: FSM to IDLE, counter to 0, output_axis_tvalid=0, status_valid=0, status fields=0, output tdata/tlast/tuser=0.
REQ-032 Reset mid-frame SHALL discard the partial frame, with no status pulse and no output tlast generated.

Structure
REQ-033 FSM state encoding SHALL be local constants; no shared package is required.
REQ-034 The output register stage MAY be the existing sub-module axis_register; no other sub-modules.

Verification
REQ-035 min=4, max=16, 6-beat frame 0x01..0x06 -> identical 6 beats out; status length=6, padded=0, truncated=0.
REQ-036 min=4, 2-beat frame 0xAA,0xBB with tuser=1 on last -> out 0xAA,0xBB,0x00,0x00; tlast on beat 4 with tuser=1; status length=4, padded=1.
REQ-037 max=3, 5-beat frame -> out 3 beats, third with tlast=1 and tuser=1; input beats 4-5 accepted and dropped; status length=3, truncated=1.
REQ-038 Random output_axis_tready (50%) with back-to-back frames of lengths 1, 4 and 20 (min=4, max=16) -> stable data under stall; lengths out 4, 4, 16.
REQ-039 rst asserted during PAD after 2 of 4 beats -> tvalid=0 immediately, no status pulse; the next 5-beat frame passes correctly.
REQ-040 length_min=0, length_max=0 -> treated as 1; every frame emits 1 beat with tlast=1; frames longer than 1 beat are flagged truncated.

Source files
------------

// File: rtl/axis_frame_length_adjust_pkg.sv
// Length arithmetic shared by the frame length adjuster: clamping of programmed
// minimum/maximum frame lengths to their effective values.
package axis_frame_length_adjust_pkg;

  localparam int LEN_CALC_W = 32;

  typedef logic [LEN_CALC_W-1:0] len_calc_t;

  // A programmed length of zero behaves as a one-beat length.
  function automatic len_calc_t clamp_len(input len_calc_t v);
    return (v == '0) ? len_calc_t'(1) : v;
  endfunction

  function automatic len_calc_t effective_min(input len_calc_t mn, input len_calc_t mx);
    len_calc_t a;
    len_calc_t b;
    a = clamp_len(mn);
    b = clamp_len(mx);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/axis_frame_length_adjust.sv
// AXI-stream frame length adjuster: pads short frames with zero beats, truncates
// long frames, and reports per-frame status after each output tlast handshake.
//
// state       | meaning
// ST_IDLE     | waiting for the first beat of a frame
// ST_TRANSFER | passing beats through, counting emitted beats
// ST_PAD      | input stalled, emitting zero beats up to the minimum
// ST_TRUNCATE | maximum reached, dropping input up to its tlast
module axis_frame_length_adjust
  import axis_frame_length_adjust_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int LENGTH_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   input_axis_tdata,
  input  logic                    input_axis_tvalid,
  output logic                    input_axis_tready,
  input  logic                    input_axis_tlast,
  input  logic                    input_axis_tuser,
  output logic [DATA_WIDTH-1:0]   output_axis_tdata,
  output logic                    output_axis_tvalid,
  input  logic                    output_axis_tready,
  output logic                    output_axis_tlast,
  output logic                    output_axis_tuser,
  input  logic [LENGTH_WIDTH-1:0] length_min,
  input  logic [LENGTH_WIDTH-1:0] length_max,
  output logic                    status_valid,
  output logic [LENGTH_WIDTH-1:0] status_frame_length,
  output logic                    status_padded,
  output logic                    status_truncated
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRANSFER = 2'd1,
    ST_PAD      = 2'd2,
    ST_TRUNCATE = 2'd3
  } state_t;

  localparam logic [LENGTH_WIDTH-1:0] LEN_ONE = LENGTH_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [LENGTH_WIDTH-1:0] count_q, count_d, count_next;
  logic [LENGTH_WIDTH-1:0] min_q, max_q;
  logic [LENGTH_WIDTH-1:0] in_min_eff, in_max_eff, cur_min, cur_max;
  logic                    pad_user_q;
  logic                    can_load, in_ready, in_hs;
  logic                    capture, save_user;

  logic                    load;
  logic [DATA_WIDTH-1:0]   ld_data;
  logic                    ld_last, ld_user, ld_pad, ld_trunc;

  logic                    out_valid_q, out_last_q, out_user_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [LENGTH_WIDTH-1:0] tag_len_q;
  logic                    tag_pad_q, tag_trunc_q;
  logic                    out_last_hs;

  logic                    stat_valid_q, stat_pad_q, stat_trunc_q;
  logic [LENGTH_WIDTH-1:0] stat_len_q;

  // Lengths are taken live on the first beat of a frame, then from the capture.
  assign in_max_eff = LENGTH_WIDTH'(clamp_len(len_calc_t'(length_max)));
  assign in_min_eff = LENGTH_WIDTH'(effective_min(len_calc_t'(length_min), len_calc_t'(length_max)));
  assign cur_min    = (state_q == ST_IDLE) ? in_min_eff : min_q;
  assign cur_max    = (state_q == ST_IDLE) ? in_max_eff : max_q;
  assign count_next = (state_q == ST_IDLE) ? LEN_ONE : count_q + LEN_ONE;

  assign can_load    = ~out_valid_q | output_axis_tready;
  assign in_ready    = ~rst & can_load & (state_q != ST_PAD);
  assign in_hs       = input_axis_tvalid & in_ready;
  assign out_last_hs = out_valid_q & output_axis_tready & out_last_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    capture   = 1'b0;
    save_user = 1'b0;
    load      = 1'b0;
    ld_data   = '0;
    ld_last   = 1'b0;
    ld_user   = 1'b0;
    ld_pad    = 1'b0;
    ld_trunc  = 1'b0;
    case (state_q)
      ST_IDLE, ST_TRANSFER: begin
        if (in_hs) begin
          load    = 1'b1;
          ld_data = input_axis_tdata;
          count_d = count_next;
          capture = (state_q == ST_IDLE);
          if (input_axis_tlast) begin
            if (count_next >= cur_min) begin
              ld_last = 1'b1;
              ld_user = input_axis_tuser;
              state_d = ST_IDLE;
            end else begin
              save_user = 1'b1;
              state_d   = ST_PAD;
            end
          end else if (count_next >= cur_max) begin
            ld_last  = 1'b1;
            ld_user  = 1'b1;
            ld_trunc = 1'b1;
            state_d  = ST_TRUNCATE;
          end else begin
            ld_user = input_axis_tuser;
            state_d = ST_TRANSFER;
          end
        end
      end
      ST_PAD: begin
        if (can_load) begin
          load    = 1'b1;
          count_d = count_q + LEN_ONE;
          if (count_d >= min_q) begin
            ld_last = 1'b1;
            ld_user = pad_user_q;
            ld_pad  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_TRUNCATE: begin
        if (in_hs && input_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      min_q      <= '0;
      max_q      <= '0;
      pad_user_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (capture) begin
        min_q <= in_min_eff;
        max_q <= in_max_eff;
      end
      if (save_user) pad_user_q <= input_axis_tuser;
    end
  end

  // Output stage; the tag travels with the beat so status reflects the frame
  // whose tlast actually handshakes, even while the next frame is loading.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
      tag_len_q   <= '0;
      tag_pad_q   <= 1'b0;
      tag_trunc_q <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= ld_data;
      out_last_q  <= ld_last;
      out_user_q  <= ld_user;
      tag_len_q   <= count_d;
      tag_pad_q   <= ld_pad;
      tag_trunc_q <= ld_trunc;
    end else if (output_axis_tready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_valid_q <= 1'b0;
      stat_len_q   <= '0;
      stat_pad_q   <= 1'b0;
      stat_trunc_q <= 1'b0;
    end else begin
      stat_valid_q <= out_last_hs;
      if (out_last_hs) begin
        stat_len_q   <= tag_len_q;
        stat_pad_q   <= tag_pad_q;
        stat_trunc_q <= tag_trunc_q;
      end
    end
  end

  assign input_axis_tready   = in_ready;
  assign output_axis_tdata   = out_data_q;
  assign output_axis_tvalid  = out_valid_q;
  assign output_axis_tlast   = out_last_q;
  assign output_axis_tuser   = out_user_q;
  assign status_valid        = stat_valid_q;
  assign status_frame_length = stat_len_q;
  assign status_padded       = stat_pad_q;
  assign status_truncated    = stat_trunc_q;

endmodule

// File: tb/tb_axis_frame_length_adjust.sv
// Bench for axis_frame_length_adjust: frame-level reference model with queued
// expected beats/status, compared every cycle against the DUT outputs.
module tb_axis_frame_length_adjust;

  localparam int DW = 8;
  localparam int LW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  typedef struct packed {
    logic [LW-1:0] len;
    logic          pad;
    logic          trunc;
  } stat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic          in_user = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          out_user;
  logic [LW-1:0] length_min = '0;
  logic [LW-1:0] length_max = '0;
  logic          status_valid;
  logic [LW-1:0] status_frame_length;
  logic          status_padded;
  logic          status_truncated;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;
  bit rdy_rand = 1'b0;
  bit gap_en   = 1'b0;

  beat_t fr[$];
  beat_t exp_q[$];
  beat_t m_out[$];
  stat_t exp_st[$];
  stat_t m_st;

  always #5 clk = ~clk;

  axis_frame_length_adjust #(.DATA_WIDTH(DW), .LENGTH_WIDTH(LW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .input_axis_tdata    (in_data),
    .input_axis_tvalid   (in_valid),
    .input_axis_tready   (in_ready),
    .input_axis_tlast    (in_last),
    .input_axis_tuser    (in_user),
    .output_axis_tdata   (out_data),
    .output_axis_tvalid  (out_valid),
    .output_axis_tready  (out_ready),
    .output_axis_tlast   (out_last),
    .output_axis_tuser   (out_user),
    .length_min          (length_min),
    .length_max          (length_max),
    .status_valid        (status_valid),
    .status_frame_length (status_frame_length),
    .status_padded       (status_padded),
    .status_truncated    (status_truncated)
  );

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Frame-level reference: what a whole input frame must become on the output.
  function automatic void model_frame(input beat_t fin[$], input int mn, input int mx);
    int    emn, emx, n;
    beat_t b;
    m_out.delete();
    emx = (mx == 0) ? 1 : mx;
    emn = (mn == 0) ? 1 : mn;
    if (emn > emx) emn = emx;
    n = fin.size();
    if (n > emx) begin
      for (int i = 0; i < emx; i++) begin
        b = fin[i];
        if (i == emx - 1) begin b.last = 1'b1; b.user = 1'b1; end
        m_out.push_back(b);
      end
      m_st.len = LW'(emx); m_st.pad = 1'b0; m_st.trunc = 1'b1;
    end else if (n < emn) begin
      for (int i = 0; i < n; i++) begin
        b = fin[i];
        if (i == n - 1) begin b.last = 1'b0; b.user = 1'b0; end
        m_out.push_back(b);
      end
      for (int k = n; k < emn; k++) begin
        b.data = '0;
        b.last = (k == emn - 1);
        b.user = (k == emn - 1) ? fin[n-1].user : 1'b0;
        m_out.push_back(b);
      end
      m_st.len = LW'(emn); m_st.pad = 1'b1; m_st.trunc = 1'b0;
    end else begin
      foreach (fin[i]) m_out.push_back(fin[i]);
      m_st.len = LW'(n); m_st.pad = 1'b0; m_st.trunc = 1'b0;
    end
  endfunction

  function automatic void make_frame(input int n, input bit last_user);
    beat_t b;
    fr.delete();
    for (int i = 0; i < n; i++) begin
      b.data = DW'($urandom);
      b.last = (i == n - 1);
      b.user = (i == n - 1) ? last_user : 1'(($urandom_range(3) == 0));
      fr.push_back(b);
    end
  endfunction

  task automatic drive_frame(input int mn, input int mx, input bit use_model);
    bit hs;
    int waited;
    if (use_model) begin
      model_frame(fr, mn, mx);
      foreach (m_out[i]) exp_q.push_back(m_out[i]);
      exp_st.push_back(m_st);
    end
    length_min = LW'(mn);
    length_max = LW'(mx);
    for (int i = 0; i < fr.size(); i++) begin
      if (gap_en && $urandom_range(3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = fr[i].data;
      in_last  = fr[i].last;
      in_user  = fr[i].user;
      hs = 1'b0;
      waited = 0;
      while (!hs) begin
        @(negedge clk);
        hs = in_ready;
        @(posedge clk);
        #1;
        waited++;
        if (!hs && waited > 200) begin
          chk(1'b0, "input_handshake_timeout", waited, 200);
          hs = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_user  = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || exp_st.size() != 0) && k < 2000) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(exp_q.size() == 0, "drain_beats", exp_q.size(), 0);
    chk(exp_st.size() == 0, "drain_status", exp_st.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
  end

  bit            stall_prev = 1'b0;
  bit            lasths_prev = 1'b0;
  beat_t         held;
  beat_t         ce;
  stat_t         cs;

  always @(negedge clk) begin
    if (!cmp_en) begin
      stall_prev  = 1'b0;
      lasths_prev = 1'b0;
    end else begin
      if (stall_prev)
        chk(out_valid && out_data == held.data && out_last == held.last && out_user == held.user,
            "stall_hold", {out_valid, out_data, out_last, out_user}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", out_data, 0);
        end else begin
          ce = exp_q.pop_front();
          chk(out_data == ce.data, "beat_data", out_data, ce.data);
          chk(out_last == ce.last, "beat_tlast", out_last, ce.last);
          chk(out_user == ce.user, "beat_tuser", out_user, ce.user);
        end
      end
      if (status_valid || lasths_prev)
        chk(status_valid == lasths_prev, "status_timing", status_valid, lasths_prev);
      if (status_valid) begin
        if (exp_st.size() == 0) begin
          chk(1'b0, "unexpected_status", status_frame_length, 0);
        end else begin
          cs = exp_st.pop_front();
          chk(status_frame_length == cs.len, "status_length", status_frame_length, cs.len);
          chk(status_padded == cs.pad, "status_padded", status_padded, cs.pad);
          chk(status_truncated == cs.trunc, "status_truncated", status_truncated, cs.trunc);
        end
      end
      stall_prev  = out_valid && !out_ready;
      held.data   = out_data;
      held.last   = out_last;
      held.user   = out_user;
      lasths_prev = out_valid && out_ready && out_last;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    beat_t b;
    int    mn, mx, n;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(out_valid == 1'b0, "reset_tvalid", out_valid, 0);
    chk(out_data == '0 && out_last == 1'b0 && out_user == 1'b0, "reset_out_fields",
        {out_data, out_last, out_user}, 0);
    chk(status_valid == 1'b0, "reset_status_valid", status_valid, 0);
    chk(status_frame_length == '0 && !status_padded && !status_truncated, "reset_status_fields",
        {status_frame_length, status_padded, status_truncated}, 0);
    chk(in_ready == 1'b0, "reset_tready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Pin the model with hand-derived results.
    fr.delete();
    b.data = 8'hAA; b.last = 1'b0; b.user = 1'b0; fr.push_back(b);
    b.data = 8'hBB; b.last = 1'b1; b.user = 1'b1; fr.push_back(b);
    model_frame(fr, 4, 16);
    chk(m_out.size() == 4, "pin_pad_size", m_out.size(), 4);
    chk(m_out[1] == {8'hBB, 1'b0, 1'b0}, "pin_pad_beat2", m_out[1], {8'hBB, 2'b00});
    chk(m_out[3] == {8'h00, 1'b1, 1'b1}, "pin_pad_beat4", m_out[3], {8'h00, 2'b11});
    chk(m_st == {16'd4, 1'b1, 1'b0}, "pin_pad_status", m_st, {16'd4, 2'b10});
    make_frame(5, 1'b0);
    model_frame(fr, 1, 3);
    chk(m_out.size() == 3 && m_out[2].last && m_out[2].user, "pin_trunc_beats", m_out.size(), 3);
    chk(m_st == {16'd3, 1'b0, 1'b1}, "pin_trunc_status", m_st, {16'd3, 2'b01});
    make_frame(20, 1'b0);
    model_frame(fr, 4, 16);
    chk(m_st.len == 16'd16, "pin_len20", m_st.len, 16);
    make_frame(1, 1'b0);
    model_frame(fr, 4, 16);
    chk(m_st.len == 16'd4, "pin_len1", m_st.len, 4);
    make_frame(3, 1'b0);
    model_frame(fr, 0, 0);
    chk(m_out.size() == 1 && m_out[0].last && m_st.trunc, "pin_zero_lengths", m_out.size(), 1);

    cmp_en = 1'b1;

    fr.delete();
    for (int i = 1; i <= 6; i++) begin
      b.data = DW'(i); b.last = (i == 6); b.user = 1'b0; fr.push_back(b);
    end
    drive_frame(4, 16, 1'b1);

    fr.delete();
    b.data = 8'hAA; b.last = 1'b0; b.user = 1'b0; fr.push_back(b);
    b.data = 8'hBB; b.last = 1'b1; b.user = 1'b1; fr.push_back(b);
    drive_frame(4, 16, 1'b1);

    make_frame(5, 1'b0);
    drive_frame(1, 3, 1'b1);

    rdy_rand = 1'b1;
    make_frame(1, 1'b1);
    drive_frame(4, 16, 1'b1);
    make_frame(4, 1'b0);
    drive_frame(4, 16, 1'b1);
    make_frame(20, 1'b1);
    drive_frame(4, 16, 1'b1);

    make_frame(1, 1'b1);
    drive_frame(0, 0, 1'b1);
    make_frame(3, 1'b0);
    drive_frame(0, 0, 1'b1);

    make_frame(5, 1'b1);
    drive_frame(5, 5, 1'b1);
    make_frame(8, 1'b0);
    drive_frame(4, 8, 1'b1);
    make_frame(9, 1'b1);
    drive_frame(4, 8, 1'b1);
    make_frame(3, 1'b1);
    drive_frame(9, 6, 1'b1);
    drain();

    // Reset while padding: two of four beats emitted, pad in flight.
    rdy_rand = 1'b0;
    cmp_en   = 1'b0;
    fr.delete();
    b.data = 8'h11; b.last = 1'b0; b.user = 1'b0; fr.push_back(b);
    b.data = 8'h22; b.last = 1'b1; b.user = 1'b1; fr.push_back(b);
    drive_frame(4, 16, 1'b0);
    @(negedge clk);
    chk(in_ready == 1'b0, "pad_tready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk(out_valid == 1'b0, "midpad_reset_tvalid", out_valid, 0);
    chk(out_data == '0 && out_last == 1'b0, "midpad_reset_fields", {out_data, out_last}, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk(status_valid == 1'b0, "midpad_no_status", status_valid, 0);
      if (i < 3) chk(in_ready == 1'b0, "midpad_reset_tready", in_ready, 0);
      if (i == 2) begin
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    end
    chk(out_valid == 1'b0, "post_reset_idle", out_valid, 0);
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    make_frame(5, 1'b0);
    drive_frame(4, 16, 1'b1);
    drain();

    gap_en   = 1'b1;
    rdy_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      n  = $urandom_range(1, 20);
      mn = $urandom_range(0, 10);
      mx = ($urandom_range(9) == 0) ? 65535 : $urandom_range(0, 16);
      make_frame(n, 1'($urandom_range(1)));
      drive_frame(mn, mx, 1'b1);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
